baud_tick_generator: RTL and testbench



---
 rtl/baud_tick_generator_if.sv | 25 ++
 rtl/baud_tick_generator.sv | 90 +++++++++
 tb/tb_baud_tick_generator.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/baud_tick_generator_if.sv
// Control and status bundle between the UART and its fractional baud tick generator.
// The master side programs the rate and realigns the phase; the slave side returns the tick strobes.
interface baud_tick_generator_if #(
  parameter int ACC_WIDTH   = 24,
  parameter int PHASE_WIDTH = 4
);
  logic                   enable;
  logic [ACC_WIDTH-1:0]   inc_in;
  logic                   inc_load;
  logic                   phase_clear;
  logic                   rx_tick;
  logic                   tx_tick;
  logic [PHASE_WIDTH-1:0] rx_phase;
  logic [ACC_WIDTH-1:0]   inc_out;

  modport master (
    output enable, inc_in, inc_load, phase_clear,
    input  rx_tick, tx_tick, rx_phase, inc_out
  );

  modport slave (
    input  enable, inc_in, inc_load, phase_clear,
    output rx_tick, tx_tick, rx_phase, inc_out
  );
endinterface

// File: rtl/baud_tick_generator.sv
// NCO baud generator: a phase accumulator carry gives rx ticks at baud*OS, and every OS-th
// rx tick is also a tx tick. The rate is reprogrammable at runtime through inc_in/inc_load.
module baud_tick_generator #(
  parameter int CLOCK_RATE         = 100000000,
  parameter int BAUD_RATE          = 9600,
  parameter int RX_OVERSAMPLE_RATE = 16,
  parameter int ACC_WIDTH          = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  baud_tick_generator_if.slave bus
);
  localparam int PHASE_WIDTH = ($clog2(RX_OVERSAMPLE_RATE) < 1) ? 1 : $clog2(RX_OVERSAMPLE_RATE);

  // Rounded reset increment; the 64-bit arithmetic keeps BAUD*OS*2^ACC_WIDTH from overflowing.
  localparam logic [63:0] INC_NUM      = 64'(BAUD_RATE) * 64'(RX_OVERSAMPLE_RATE) * (64'd1 << ACC_WIDTH);
  localparam logic [63:0] INC_RESET_64 = (INC_NUM + 64'(CLOCK_RATE) / 64'd2) / 64'(CLOCK_RATE);
  localparam logic [ACC_WIDTH-1:0] INC_RESET = INC_RESET_64[ACC_WIDTH-1:0];
  localparam logic [PHASE_WIDTH-1:0] PHASE_LAST = PHASE_WIDTH'(RX_OVERSAMPLE_RATE - 1);

  if (ACC_WIDTH < 8 || ACC_WIDTH > 32) begin : g_bad_width
    $error("baud_tick_generator: ACC_WIDTH must be within 8..32");
  end
  if (RX_OVERSAMPLE_RATE < 2) begin : g_bad_os
    $error("baud_tick_generator: RX_OVERSAMPLE_RATE must be at least 2");
  end
  if (INC_RESET_64 == 64'd0 || INC_RESET_64 >= (64'd1 << ACC_WIDTH)) begin : g_bad_inc
    $error("baud_tick_generator: reset increment is 0 or does not fit in ACC_WIDTH bits");
  end

  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [ACC_WIDTH-1:0]   inc_q, inc_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic                   rx_tick_q, rx_tick_d;
  logic                   tx_tick_q, tx_tick_d;
  logic [ACC_WIDTH:0]     sum;

  always_comb begin
    acc_d     = acc_q;
    inc_d     = inc_q;
    phase_d   = phase_q;
    rx_tick_d = 1'b0;
    tx_tick_d = 1'b0;
    sum       = {1'b0, acc_q} + {1'b0, inc_q};

    // A load of zero would stall the NCO forever, so it is ignored (but still blocks accumulation).
    if (bus.inc_load) begin
      if (bus.inc_in != '0) begin
        inc_d   = bus.inc_in;
        acc_d   = '0;
        phase_d = '0;
      end
    end else if (bus.phase_clear) begin
      acc_d   = '0;
      phase_d = '0;
    end else if (bus.enable) begin
      acc_d     = sum[ACC_WIDTH-1:0];
      rx_tick_d = sum[ACC_WIDTH];
      if (sum[ACC_WIDTH]) begin
        if (phase_q == PHASE_LAST) begin
          phase_d   = '0;
          tx_tick_d = 1'b1;
        end else begin
          phase_d = phase_q + PHASE_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= '0;
      inc_q     <= INC_RESET;
      phase_q   <= '0;
      rx_tick_q <= 1'b0;
      tx_tick_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      inc_q     <= inc_d;
      phase_q   <= phase_d;
      rx_tick_q <= rx_tick_d;
      tx_tick_q <= tx_tick_d;
    end
  end

  assign bus.rx_tick  = rx_tick_q;
  assign bus.tx_tick  = tx_tick_q;
  assign bus.rx_phase = phase_q;
  assign bus.inc_out  = inc_q;
endmodule

// File: tb/tb_baud_tick_generator.sv
// Directed bench for baud_tick_generator at CLOCK_RATE=16, BAUD=1, OS=4, ACC_WIDTH=8 (reset increment 64).
// Inputs change 1 time unit after each rising edge; outputs are sampled at that same point.
module tb_baud_tick_generator;
  localparam int W  = 8;
  localparam int PW = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  baud_tick_generator_if #(.ACC_WIDTH(W), .PHASE_WIDTH(PW)) bus ();

  baud_tick_generator #(
    .CLOCK_RATE(16), .BAUD_RATE(1), .RX_OVERSAMPLE_RATE(4), .ACC_WIDTH(W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.enable = 1'b1;
    bus.inc_in = '0;
    bus.inc_load = 1'b0;
    bus.phase_clear = 1'b0;
    step();
    step();
    n_checks++; if (bus.rx_tick !== 1'b0) begin n_fail++; $display("FAIL reset_rx_tick: got %b expected 0", bus.rx_tick); end
    n_checks++; if (bus.tx_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tx_tick: got %b expected 0", bus.tx_tick); end
    n_checks++; if (bus.rx_phase !== 2'd0) begin n_fail++; $display("FAIL reset_rx_phase: got %0d expected 0", bus.rx_phase); end
    n_checks++; if (bus.inc_out !== 8'd64) begin n_fail++; $display("FAIL reset_inc_out: got %0d expected 64", bus.inc_out); end
    reset = 1'b0;
  endtask

  task automatic test_default_rate();
    for (int k = 1; k <= 32; k++) begin
      logic       exp_rx, exp_tx;
      logic [1:0] exp_ph;
      step();
      exp_rx = (k % 4 == 0);
      exp_tx = (k % 16 == 0);
      exp_ph = 2'((k / 4) % 4);
      n_checks++; if (bus.rx_tick !== exp_rx) begin n_fail++; $display("FAIL default_rx cycle %0d: got %b expected %b", k, bus.rx_tick, exp_rx); end
      n_checks++; if (bus.tx_tick !== exp_tx) begin n_fail++; $display("FAIL default_tx cycle %0d: got %b expected %b", k, bus.tx_tick, exp_tx); end
      n_checks++; if (bus.rx_phase !== exp_ph) begin n_fail++; $display("FAIL default_phase cycle %0d: got %0d expected %0d", k, bus.rx_phase, exp_ph); end
    end
    n_checks++; if (bus.inc_out !== 8'd64) begin n_fail++; $display("FAIL default_inc_out: got %0d expected 64", bus.inc_out); end
  endtask

  task automatic test_fractional();
    int rx_cnt = 0, tx_cnt = 0, last = 0, bad_iv = 0, bad_co = 0;
    bus.inc_in = 8'd100;
    bus.inc_load = 1'b1;
    step();
    bus.inc_load = 1'b0;
    n_checks++; if (bus.inc_out !== 8'd100) begin n_fail++; $display("FAIL frac_inc_out: got %0d expected 100", bus.inc_out); end
    for (int n = 1; n <= 256; n++) begin
      step();
      if (bus.rx_tick === 1'b1) begin
        if (n - last < 2 || n - last > 3) bad_iv++;
        last = n;
        rx_cnt++;
      end
      if (bus.tx_tick === 1'b1) begin
        tx_cnt++;
        if (bus.rx_tick !== 1'b1) bad_co++;
      end
    end
    n_checks++; if (rx_cnt != 100) begin n_fail++; $display("FAIL frac_rx_count: got %0d expected 100", rx_cnt); end
    n_checks++; if (tx_cnt != 25) begin n_fail++; $display("FAIL frac_tx_count: got %0d expected 25", tx_cnt); end
    n_checks++; if (bad_iv != 0) begin n_fail++; $display("FAIL frac_interval: got %0d intervals outside 2..3 expected 0", bad_iv); end
    n_checks++; if (bad_co != 0) begin n_fail++; $display("FAIL frac_tx_without_rx: got %0d expected 0", bad_co); end
    n_checks++; if (bus.rx_phase !== 2'd0) begin n_fail++; $display("FAIL frac_end_phase: got %0d expected 0", bus.rx_phase); end
  endtask

  task automatic test_load_mid_run();
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (bus.rx_phase === 2'd2) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL load_mid_wait: rx_phase got %0d expected 2 within 20 cycles", bus.rx_phase); end
    bus.inc_in = 8'd128;
    bus.inc_load = 1'b1;
    step();
    bus.inc_load = 1'b0;
    n_checks++; if (bus.rx_phase !== 2'd0) begin n_fail++; $display("FAIL load_mid_phase: got %0d expected 0", bus.rx_phase); end
    n_checks++; if (bus.rx_tick !== 1'b0) begin n_fail++; $display("FAIL load_mid_tick: got %b expected 0", bus.rx_tick); end
    for (int j = 1; j <= 10; j++) begin
      logic exp_rx;
      step();
      exp_rx = (j % 2 == 0);
      n_checks++; if (bus.rx_tick !== exp_rx) begin n_fail++; $display("FAIL load_mid_cadence cycle %0d: got %b expected %b", j, bus.rx_tick, exp_rx); end
    end
    n_checks++; if (bus.rx_phase !== 2'd1) begin n_fail++; $display("FAIL load_mid_phase_after: got %0d expected 1", bus.rx_phase); end
    bus.inc_in = 8'd0;
    bus.inc_load = 1'b1;
    step();
    bus.inc_load = 1'b0;
    n_checks++; if (bus.inc_out !== 8'd128) begin n_fail++; $display("FAIL load_zero_inc_out: got %0d expected 128", bus.inc_out); end
    n_checks++; if (bus.rx_phase !== 2'd1) begin n_fail++; $display("FAIL load_zero_phase: got %0d expected 1", bus.rx_phase); end
    n_checks++; if (bus.rx_tick !== 1'b0) begin n_fail++; $display("FAIL load_zero_tick: got %b expected 0", bus.rx_tick); end
    for (int j = 1; j <= 4; j++) begin
      logic exp_rx;
      step();
      exp_rx = (j % 2 == 0);
      n_checks++; if (bus.rx_tick !== exp_rx) begin n_fail++; $display("FAIL load_zero_cadence cycle %0d: got %b expected %b", j, bus.rx_tick, exp_rx); end
    end
    n_checks++; if (bus.rx_phase !== 2'd3) begin n_fail++; $display("FAIL load_zero_phase_after: got %0d expected 3", bus.rx_phase); end
  endtask

  task automatic test_phase_clear();
    bus.inc_in = 8'd64;
    bus.inc_load = 1'b1;
    step();
    bus.inc_load = 1'b0;
    for (int j = 1; j <= 3; j++) step();
    bus.phase_clear = 1'b1;
    step();
    bus.phase_clear = 1'b0;
    n_checks++; if (bus.rx_tick !== 1'b0) begin n_fail++; $display("FAIL clear_suppress: got %b expected 0", bus.rx_tick); end
    for (int j = 1; j <= 4; j++) begin
      logic exp_rx;
      step();
      exp_rx = (j == 4);
      n_checks++; if (bus.rx_tick !== exp_rx) begin n_fail++; $display("FAIL clear_next_tick cycle %0d: got %b expected %b", j, bus.rx_tick, exp_rx); end
    end
    bus.inc_in = 8'd32;
    bus.inc_load = 1'b1;
    bus.phase_clear = 1'b1;
    step();
    bus.inc_load = 1'b0;
    bus.phase_clear = 1'b0;
    n_checks++; if (bus.inc_out !== 8'd32) begin n_fail++; $display("FAIL prio_inc_out: got %0d expected 32", bus.inc_out); end
    n_checks++; if (bus.rx_phase !== 2'd0) begin n_fail++; $display("FAIL prio_phase: got %0d expected 0", bus.rx_phase); end
    for (int j = 1; j <= 8; j++) begin
      logic exp_rx;
      step();
      exp_rx = (j == 8);
      n_checks++; if (bus.rx_tick !== exp_rx) begin n_fail++; $display("FAIL prio_first_tick cycle %0d: got %b expected %b", j, bus.rx_tick, exp_rx); end
    end
  endtask

  task automatic test_enable_gating();
    bus.inc_in = 8'd64;
    bus.inc_load = 1'b1;
    step();
    bus.inc_load = 1'b0;
    for (int j = 1; j <= 6; j++) step();
    n_checks++; if (bus.rx_phase !== 2'd1) begin n_fail++; $display("FAIL gate_pre_phase: got %0d expected 1", bus.rx_phase); end
    bus.enable = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      step();
      n_checks++; if (bus.rx_tick !== 1'b0) begin n_fail++; $display("FAIL gate_no_tick cycle %0d: got %b expected 0", j, bus.rx_tick); end
      n_checks++; if (bus.rx_phase !== 2'd1) begin n_fail++; $display("FAIL gate_hold_phase cycle %0d: got %0d expected 1", j, bus.rx_phase); end
    end
    bus.enable = 1'b1;
    for (int j = 1; j <= 2; j++) begin
      logic exp_rx;
      step();
      exp_rx = (j == 2);
      n_checks++; if (bus.rx_tick !== exp_rx) begin n_fail++; $display("FAIL gate_resume cycle %0d: got %b expected %b", j, bus.rx_tick, exp_rx); end
    end
    n_checks++; if (bus.rx_phase !== 2'd2) begin n_fail++; $display("FAIL gate_post_phase: got %0d expected 2", bus.rx_phase); end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    bus.inc_in = 8'd100;
    bus.inc_load = 1'b1;
    step();
    bus.inc_load = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (bus.rx_phase === 2'd3) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL rst_mid_wait: rx_phase got %0d expected 3 within 30 cycles", bus.rx_phase); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if (bus.rx_tick !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rx_tick: got %b expected 0", bus.rx_tick); end
    n_checks++; if (bus.tx_tick !== 1'b0) begin n_fail++; $display("FAIL rst_mid_tx_tick: got %b expected 0", bus.tx_tick); end
    n_checks++; if (bus.rx_phase !== 2'd0) begin n_fail++; $display("FAIL rst_mid_phase: got %0d expected 0", bus.rx_phase); end
    n_checks++; if (bus.inc_out !== 8'd64) begin n_fail++; $display("FAIL rst_mid_inc_out: got %0d expected 64", bus.inc_out); end
    for (int k = 1; k <= 16; k++) begin
      logic       exp_rx, exp_tx;
      logic [1:0] exp_ph;
      step();
      exp_rx = (k % 4 == 0);
      exp_tx = (k == 16);
      exp_ph = 2'((k / 4) % 4);
      n_checks++; if (bus.rx_tick !== exp_rx) begin n_fail++; $display("FAIL rst_mid_rx cycle %0d: got %b expected %b", k, bus.rx_tick, exp_rx); end
      n_checks++; if (bus.tx_tick !== exp_tx) begin n_fail++; $display("FAIL rst_mid_tx cycle %0d: got %b expected %b", k, bus.tx_tick, exp_tx); end
      n_checks++; if (bus.rx_phase !== exp_ph) begin n_fail++; $display("FAIL rst_mid_phase_seq cycle %0d: got %0d expected %0d", k, bus.rx_phase, exp_ph); end
    end
  endtask

  initial begin
    test_reset();
    test_default_rate();
    test_fractional();
    test_load_mid_run();
    test_phase_clear();
    test_enable_gating();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no completion expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
